rx_frame_arbiter: RTL and testbench

- Merges the 32-bit output FIFOs of N hit receivers into one first-word-fall-through (FWFT) stream for the readout.
- Each receiver emits 4-word hit frames. Bits [29:28] carry the word-position header: 11, 10, 01, 00 in that order.
- A round-robin grant is locked to one source for a whole frame, so frames never interleave.
- The block resynchronises on stray non-head words and releases a stalled source after a timeout. Both events are counted in saturating error counters.

---
 rtl/rx_frame_pkg.sv | 27 ++
 rtl/rx_frame_arbiter_pick.sv | 30 +++
 rtl/rx_frame_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_rx_frame_arbiter.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_frame_pkg.sv
// Shared types and constants for the hit-frame readout arbiter.
// No logic: enums, header codes and a saturating-increment helper.
// Header codes give the position of each word inside a 4-word hit frame.
package rx_frame_pkg;

   localparam int WORD_W  = 32;
   localparam int HDR_LSB = 28;
   localparam int HDR_W   = 2;

   // Word-position header carried in bits [29:28], in frame order
   localparam logic [HDR_W-1:0] HDR_W0 = 2'b11;
   localparam logic [HDR_W-1:0] HDR_W1 = 2'b10;
   localparam logic [HDR_W-1:0] HDR_W2 = 2'b01;
   localparam logic [HDR_W-1:0] HDR_W3 = 2'b00;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HEAD = 2'd1,
      BODY = 2'd2
   } state_t;

   // Error counters stick at all-ones until reset
   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/rx_frame_arbiter_pick.sv
// Round-robin picker: first requester after index 'last', with wrap-around.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the pick is registered.
module rr_priority_pick #(
   parameter int N_REQ = 4,
   parameter int IDX_W = 2
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] last,
   output logic [N_REQ-1:0] grant,
   output logic             vld
);

   int pos;

   // Scan last+1, last+2, ... and keep only the first requester found
   always_comb begin
      grant = '0;
      vld   = 1'b0;
      pos   = 0;
      for (int k = 1; k <= N_REQ; k++) begin
         pos = (int'(last) + k) % N_REQ;
         if (!vld && req[pos]) begin
            grant[pos] = 1'b1;
            vld        = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rx_frame_arbiter.sv
// Merges N receiver FWFT FIFOs into one FWFT stream, whole frames at a time.
// Latency: 1-cycle arbitration per frame, then one word per cycle pass-through.
// Backpressure: sources pop only on OUT_READ with data shown; stalled sources time out.
module rx_frame_arbiter
   import rx_frame_pkg::*;
#(
   parameter int N_SRC       = 4,
   parameter int FRAME_WORDS = 4,
   parameter int TIMEOUT     = 1023
) (
   input  logic                      BUS_CLK,
   input  logic                      RST,
   input  logic [N_SRC-1:0]          SRC_EN,
   input  logic [N_SRC-1:0]          SRC_EMPTY,
   input  logic [WORD_W*N_SRC-1:0]   SRC_DATA,
   output logic [N_SRC-1:0]          SRC_READ,
   input  logic                      OUT_READ,
   output logic                      OUT_EMPTY,
   output logic [WORD_W-1:0]         OUT_DATA,
   output logic [N_SRC-1:0]          GRANT,
   output logic [7:0]                DESYNC_CNT,
   output logic [7:0]                TIMEOUT_CNT
);

   localparam int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
   localparam int CNT_W = $clog2(FRAME_WORDS + 1);
   localparam int TMO_W = $clog2(TIMEOUT + 1);

   state_t             state_q, state_nxt;
   logic [N_SRC-1:0]   grant_q, grant_nxt;
   logic [IDX_W-1:0]   g_q, g_nxt;
   logic [IDX_W-1:0]   last_q, last_nxt;
   logic [CNT_W-1:0]   word_cnt_q, word_cnt_nxt;
   logic [TMO_W-1:0]   tmo_q, tmo_nxt;
   logic [7:0]         desync_q, desync_nxt;
   logic [7:0]         tocnt_q, tocnt_nxt;

   logic [N_SRC-1:0]   req;
   logic [N_SRC-1:0]   pick_oh;
   logic               pick_vld;
   logic [IDX_W-1:0]   pick_idx;
   logic [WORD_W-1:0]  g_word;
   logic               g_empty;
   logic [HDR_W-1:0]   g_hdr;

   assign req         = SRC_EN & ~SRC_EMPTY;
   assign GRANT       = grant_q;
   assign DESYNC_CNT  = desync_q;
   assign TIMEOUT_CNT = tocnt_q;

   rr_priority_pick #(
      .N_REQ (N_SRC),
      .IDX_W (IDX_W)
   ) u_pick (
      .req   (req),
      .last  (last_q),
      .grant (pick_oh),
      .vld   (pick_vld)
   );

   // One-hot pick to index, and the head word of the granted source
   always_comb begin
      pick_idx = '0;
      for (int i = 0; i < N_SRC; i++) begin
         if (pick_oh[i]) pick_idx = IDX_W'(i);
      end
      g_word  = SRC_DATA[int'(g_q)*WORD_W +: WORD_W];
      g_empty = SRC_EMPTY[g_q];
      g_hdr   = g_word[HDR_LSB +: HDR_W];
   end

   // State, grant and counter registers
   always_ff @(posedge BUS_CLK) begin
      if (RST) begin
         state_q    <= IDLE;
         grant_q    <= '0;
         g_q        <= '0;
         last_q     <= IDX_W'(N_SRC - 1);
         word_cnt_q <= '0;
         tmo_q      <= '0;
         desync_q   <= '0;
         tocnt_q    <= '0;
      end else begin
         state_q    <= state_nxt;
         grant_q    <= grant_nxt;
         g_q        <= g_nxt;
         last_q     <= last_nxt;
         word_cnt_q <= word_cnt_nxt;
         tmo_q      <= tmo_nxt;
         desync_q   <= desync_nxt;
         tocnt_q    <= tocnt_nxt;
      end
   end

   // Next-state and output decode; a pop always beats the timeout
   always_comb begin
      state_nxt    = state_q;
      grant_nxt    = grant_q;
      g_nxt        = g_q;
      last_nxt     = last_q;
      word_cnt_nxt = word_cnt_q;
      tmo_nxt      = tmo_q;
      desync_nxt   = desync_q;
      tocnt_nxt    = tocnt_q;
      SRC_READ     = '0;
      OUT_EMPTY    = 1'b1;
      OUT_DATA     = '0;

      case (state_q)
         IDLE: begin
            if (pick_vld) begin
               state_nxt = HEAD;
               grant_nxt = pick_oh;
               g_nxt     = pick_idx;
               tmo_nxt   = '0;
            end
         end

         HEAD: begin
            if (!g_empty) begin
               if (g_hdr == HDR_W0) begin
                  OUT_EMPTY = 1'b0;
                  OUT_DATA  = g_word;
                  if (OUT_READ) begin
                     SRC_READ     = grant_q;
                     word_cnt_nxt = CNT_W'(1);
                     tmo_nxt      = '0;
                     state_nxt    = BODY;
                  end
               end else begin
                  // Stray mid-frame word: drop it and keep hunting for a head
                  SRC_READ   = grant_q;
                  desync_nxt = sat_inc(desync_q);
                  tmo_nxt    = '0;
               end
            end else if (tmo_q == TMO_W'(TIMEOUT)) begin
               state_nxt = IDLE;
               grant_nxt = '0;
               tmo_nxt   = '0;
            end else begin
               tmo_nxt = tmo_q + 1'b1;
            end
         end

         BODY: begin
            OUT_EMPTY = g_empty;
            OUT_DATA  = g_word;
            if (!g_empty) begin
               if (OUT_READ) begin
                  SRC_READ = grant_q;
                  tmo_nxt  = '0;
                  if (word_cnt_q == CNT_W'(FRAME_WORDS - 1)) begin
                     state_nxt    = IDLE;
                     grant_nxt    = '0;
                     last_nxt     = g_q;
                     word_cnt_nxt = '0;
                  end else begin
                     word_cnt_nxt = word_cnt_q + 1'b1;
                  end
               end
            end else if (tmo_q == TMO_W'(TIMEOUT)) begin
               // Source stalled mid-frame: abandon the partial frame
               state_nxt    = IDLE;
               grant_nxt    = '0;
               last_nxt     = g_q;
               word_cnt_nxt = '0;
               tmo_nxt      = '0;
               tocnt_nxt    = sat_inc(tocnt_q);
            end else begin
               tmo_nxt = tmo_q + 1'b1;
            end
         end

         default: begin
            state_nxt = IDLE;
            grant_nxt = '0;
         end
      endcase

      // No source is drained while the block is being reset
      if (RST) SRC_READ = '0;
   end

endmodule

// File: tb/tb_rx_frame_arbiter.sv
// Directed bench for rx_frame_arbiter with queue-backed FWFT source models.
// Latency: n/a.
// Backpressure: OUT_READ driven per scenario.
module tb_rx_frame_arbiter;

   logic          BUS_CLK = 1'b0;
   logic          RST;
   logic [3:0]    SRC_EN;
   logic [3:0]    SRC_EMPTY;
   logic [127:0]  SRC_DATA;
   logic [3:0]    SRC_READ;
   logic          OUT_READ;
   logic          OUT_EMPTY;
   logic [31:0]   OUT_DATA;
   logic [3:0]    GRANT;
   logic [7:0]    DESYNC_CNT;
   logic [7:0]    TIMEOUT_CNT;

   always #5 BUS_CLK = ~BUS_CLK;

   rx_frame_arbiter dut (
      .BUS_CLK     (BUS_CLK),
      .RST         (RST),
      .SRC_EN      (SRC_EN),
      .SRC_EMPTY   (SRC_EMPTY),
      .SRC_DATA    (SRC_DATA),
      .SRC_READ    (SRC_READ),
      .OUT_READ    (OUT_READ),
      .OUT_EMPTY   (OUT_EMPTY),
      .OUT_DATA    (OUT_DATA),
      .GRANT       (GRANT),
      .DESYNC_CNT  (DESYNC_CNT),
      .TIMEOUT_CNT (TIMEOUT_CNT)
   );

   logic [31:0] srcq [4][$];
   logic [31:0] outq [$];
   logic [3:0]  grq [$];
   int          cycq [$];
   int          cyc;
   int          checks;
   int          failures;

   // Frame word: header 11,10,01,00 by position, payload tags source/frame/word
   function automatic logic [31:0] fw(input int s, input int f, input int k);
      logic [1:0] h;
      h = 2'(3 - k);
      return {2'b00, h, 16'h0000, 4'(s), 4'(f), 4'(k)};
   endfunction

   task automatic drive_src();
      for (int i = 0; i < 4; i++) begin
         if (srcq[i].size() == 0) begin
            SRC_EMPTY[i]          = 1'b1;
            SRC_DATA[32*i +: 32]  = 32'hDEAD_BEEF;
         end else begin
            SRC_EMPTY[i]          = 1'b0;
            SRC_DATA[32*i +: 32]  = srcq[i][0];
         end
      end
   endtask

   task automatic push_frame(input int s, input int f);
      for (int k = 0; k < 4; k++) srcq[s].push_back(fw(s, f, k));
      drive_src();
   endtask

   // One clock: log any output pop, apply source pops, return at the negedge
   task automatic step();
      logic [3:0] rd;
      #1;
      rd = SRC_READ;
      if (OUT_READ && !OUT_EMPTY) begin
         outq.push_back(OUT_DATA);
         grq.push_back(GRANT);
         cycq.push_back(cyc);
      end
      @(posedge BUS_CLK);
      #1;
      for (int i = 0; i < 4; i++) begin
         if (rd[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
      end
      cyc++;
      drive_src();
      @(negedge BUS_CLK);
   endtask

   task automatic do_reset();
      for (int i = 0; i < 4; i++) srcq[i].delete();
      outq.delete();
      grq.delete();
      cycq.delete();
      SRC_EN   = 4'hF;
      OUT_READ = 1'b0;
      drive_src();
      RST = 1'b1;
      step();
      step();
      RST = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      checks++; if (GRANT !== 4'b0000) begin failures++; $display("FAIL reset_grant got=%h exp=0", GRANT); end
      checks++; if (OUT_EMPTY !== 1'b1) begin failures++; $display("FAIL reset_out_empty got=%b exp=1", OUT_EMPTY); end
      checks++; if (OUT_DATA !== 32'h0) begin failures++; $display("FAIL reset_out_data got=%h exp=0", OUT_DATA); end
      checks++; if (SRC_READ !== 4'b0000) begin failures++; $display("FAIL reset_src_read got=%h exp=0", SRC_READ); end
      checks++; if (DESYNC_CNT !== 8'h00) begin failures++; $display("FAIL reset_desync got=%h exp=0", DESYNC_CNT); end
      checks++; if (TIMEOUT_CNT !== 8'h00) begin failures++; $display("FAIL reset_timeout got=%h exp=0", TIMEOUT_CNT); end
   endtask

   task automatic test_two_sources();
      logic [31:0] ew;
      logic [3:0]  eg;
      do_reset();
      push_frame(0, 1);
      push_frame(2, 1);
      OUT_READ = 1'b1;
      for (int t = 0; t < 30; t++) step();
      checks++; if (outq.size() != 8) begin failures++; $display("FAIL two_src_count got=%0d exp=8", outq.size()); end
      for (int j = 0; j < 8 && j < outq.size(); j++) begin
         ew = (j < 4) ? fw(0, 1, j) : fw(2, 1, j - 4);
         eg = (j < 4) ? 4'b0001 : 4'b0100;
         checks++; if (outq[j] !== ew) begin failures++; $display("FAIL two_src_word%0d got=%h exp=%h", j, outq[j], ew); end
         checks++; if (grq[j] !== eg) begin failures++; $display("FAIL two_src_grant%0d got=%b exp=%b", j, grq[j], eg); end
      end
      if (cycq.size() == 8) begin
         checks++; if (cycq[3] - cycq[0] != 3) begin failures++; $display("FAIL two_src_contig0 got=%0d exp=3", cycq[3] - cycq[0]); end
         checks++; if (cycq[4] - cycq[3] != 2) begin failures++; $display("FAIL two_src_gap got=%0d exp=2", cycq[4] - cycq[3]); end
         checks++; if (cycq[7] - cycq[4] != 3) begin failures++; $display("FAIL two_src_contig1 got=%0d exp=3", cycq[7] - cycq[4]); end
      end
   endtask

   task automatic test_round_robin();
      logic [31:0] ew;
      logic [3:0]  eg;
      int fr;
      do_reset();
      for (int f = 0; f < 2; f++)
         for (int s = 0; s < 4; s++) push_frame(s, f);
      OUT_READ = 1'b1;
      for (int t = 0; t < 200 && outq.size() < 32; t++) step();
      checks++; if (outq.size() != 32) begin failures++; $display("FAIL rr_count got=%0d exp=32", outq.size()); end
      for (int j = 0; j < 32 && j < outq.size(); j++) begin
         fr = j / 4;
         ew = fw(fr % 4, fr / 4, j % 4);
         eg = 4'(1 << (fr % 4));
         checks++; if (outq[j] !== ew) begin failures++; $display("FAIL rr_word%0d got=%h exp=%h", j, outq[j], ew); end
         checks++; if (grq[j] !== eg) begin failures++; $display("FAIL rr_grant%0d got=%b exp=%b", j, grq[j], eg); end
      end
   endtask

   task automatic test_desync();
      logic [31:0] ew;
      do_reset();
      srcq[1].push_back(32'h2000_0001);
      srcq[1].push_back(32'h1000_0002);
      push_frame(1, 5);
      OUT_READ = 1'b1;
      for (int t = 0; t < 30; t++) step();
      checks++; if (outq.size() != 4) begin failures++; $display("FAIL desync_count got=%0d exp=4", outq.size()); end
      for (int j = 0; j < 4 && j < outq.size(); j++) begin
         ew = fw(1, 5, j);
         checks++; if (outq[j] !== ew) begin failures++; $display("FAIL desync_word%0d got=%h exp=%h", j, outq[j], ew); end
      end
      checks++; if (DESYNC_CNT !== 8'd2) begin failures++; $display("FAIL desync_cnt got=%0d exp=2", DESYNC_CNT); end
      checks++; if (srcq[1].size() != 0) begin failures++; $display("FAIL desync_drained got=%0d exp=0", srcq[1].size()); end
   endtask

   task automatic test_timeout();
      int n;
      int t;
      int rel;
      do_reset();
      srcq[3].push_back(fw(3, 2, 0));
      srcq[3].push_back(fw(3, 2, 1));
      drive_src();
      OUT_READ = 1'b1;
      t = 0;
      while (outq.size() < 2 && t < 20) begin step(); t++; end
      checks++; if (outq.size() != 2) begin failures++; $display("FAIL tmo_first_words got=%0d exp=2", outq.size()); end
      push_frame(0, 3);
      push_frame(1, 3);
      n = 0;
      while (GRANT !== 4'b0000 && n < 1100) begin
         step();
         n++;
         if (n == 500) begin
            checks++; if (GRANT !== 4'b1000) begin failures++; $display("FAIL tmo_held got=%b exp=1000", GRANT); end
         end
      end
      rel = (cycq.size() >= 2) ? cyc - cycq[1] : -1;
      checks++; if (rel < 1023 || rel > 1027) begin failures++; $display("FAIL tmo_release got=%0d exp=1023..1027", rel); end
      checks++; if (TIMEOUT_CNT !== 8'd1) begin failures++; $display("FAIL tmo_cnt got=%0d exp=1", TIMEOUT_CNT); end
      checks++; if (outq.size() != 2) begin failures++; $display("FAIL tmo_no_extra got=%0d exp=2", outq.size()); end
      step();
      checks++; if (GRANT !== 4'b0001) begin failures++; $display("FAIL tmo_next_grant got=%b exp=0001", GRANT); end
   endtask

   task automatic test_enable();
      logic        saw0;
      logic [31:0] ew;
      do_reset();
      SRC_EN = 4'b1110;
      push_frame(0, 4);
      push_frame(1, 4);
      OUT_READ = 1'b1;
      saw0 = 1'b0;
      for (int t = 0; t < 40; t++) begin
         step();
         if (GRANT[0]) saw0 = 1'b1;
         if (outq.size() == 2 && SRC_EN[1]) SRC_EN = 4'b1100;
      end
      checks++; if (outq.size() != 4) begin failures++; $display("FAIL en_count got=%0d exp=4", outq.size()); end
      for (int j = 0; j < 4 && j < outq.size(); j++) begin
         ew = fw(1, 4, j);
         checks++; if (outq[j] !== ew) begin failures++; $display("FAIL en_word%0d got=%h exp=%h", j, outq[j], ew); end
      end
      checks++; if (saw0 !== 1'b0) begin failures++; $display("FAIL en_src0_granted got=%b exp=0", saw0); end
      checks++; if (srcq[0].size() != 4) begin failures++; $display("FAIL en_src0_left got=%0d exp=4", srcq[0].size()); end
      checks++; if (GRANT !== 4'b0000) begin failures++; $display("FAIL en_idle got=%b exp=0000", GRANT); end
   endtask

   task automatic test_reset_mid_frame();
      int t;
      do_reset();
      srcq[0].push_back(32'h2000_0001);
      push_frame(0, 6);
      push_frame(1, 6);
      OUT_READ = 1'b1;
      t = 0;
      while (outq.size() < 2 && t < 30) begin step(); t++; end
      checks++; if (outq.size() != 2) begin failures++; $display("FAIL rst_mid_progress got=%0d exp=2", outq.size()); end
      checks++; if (DESYNC_CNT !== 8'd1) begin failures++; $display("FAIL rst_mid_desync_pre got=%0d exp=1", DESYNC_CNT); end
      RST = 1'b1;
      step();
      #1;
      checks++; if (GRANT !== 4'b0000) begin failures++; $display("FAIL rst_mid_grant got=%b exp=0000", GRANT); end
      checks++; if (OUT_EMPTY !== 1'b1) begin failures++; $display("FAIL rst_mid_empty got=%b exp=1", OUT_EMPTY); end
      checks++; if (OUT_DATA !== 32'h0) begin failures++; $display("FAIL rst_mid_data got=%h exp=0", OUT_DATA); end
      checks++; if (DESYNC_CNT !== 8'd0) begin failures++; $display("FAIL rst_mid_desync got=%0d exp=0", DESYNC_CNT); end
      checks++; if (TIMEOUT_CNT !== 8'd0) begin failures++; $display("FAIL rst_mid_timeout got=%0d exp=0", TIMEOUT_CNT); end
      RST = 1'b0;
      step();
      checks++; if (GRANT !== 4'b0001) begin failures++; $display("FAIL rst_mid_first_grant got=%b exp=0001", GRANT); end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      cyc      = 0;
      RST      = 1'b1;
      SRC_EN   = 4'hF;
      OUT_READ = 1'b0;
      SRC_EMPTY = 4'hF;
      SRC_DATA  = '0;
      @(negedge BUS_CLK);
      test_reset();
      test_two_sources();
      test_round_robin();
      test_desync();
      test_timeout();
      test_enable();
      test_reset_mid_frame();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
